// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller: arbitrates CACHE_W dcache/icache pairs onto one RAM port.
// Optional COHERENCE_STATS_EN adds c2c_count / ram_rd_count transfer counters.
module coherence_bus_ctrl #(
  parameter int unsigned CACHE_W = 2
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CACHE_W-1:0]    dREN,
  input  logic [CACHE_W-1:0]    dWEN,
  input  logic [CACHE_W-1:0]    ccwrite,
  input  logic [CACHE_W-1:0]    cctrans,
  input  logic [CACHE_W-1:0]    iREN,
  input  logic [32*CACHE_W-1:0] daddr,
  input  logic [32*CACHE_W-1:0] iaddr,
  input  logic [32*CACHE_W-1:0] dstore,
  output logic [CACHE_W-1:0]    dwait,
  output logic [CACHE_W-1:0]    iwait,
  output logic [32*CACHE_W-1:0] dload,
  output logic [32*CACHE_W-1:0] iload,
  output logic [CACHE_W-1:0]    ccwait,
  output logic [CACHE_W-1:0]    ccinv,
  output logic [32*CACHE_W-1:0] ccsnoopaddr,
  input  logic [1:0]            ramstate,
  input  logic [31:0]           ramload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]           c2c_count,
  output logic [31:0]           ram_rd_count
`endif
);

  localparam int unsigned AW = (CACHE_W > 2) ? 2 : 1;
  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StCacWb, StPrRd, StPrWr, StBusRd1, StBusRd2, StBusRdX1, StBusRdX2,
    StBusWb1, StBusWb2, StBusWbX1, StBusWbX2, StImem
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      arb_q, arb_d, grant_q, grant_d, supplier_q, supplier_d;
  logic [CACHE_W-1:0] snoop_dest_q, snoop_dest_d;

  logic [31:0] daddr_w [CACHE_W];
  logic [31:0] iaddr_w [CACHE_W];
  logic [31:0] dstore_w [CACHE_W];
  logic [31:0] dload_w [CACHE_W];
  logic [31:0] iload_w [CACHE_W];

  logic [CACHE_W-1:0] dreq;
  logic               d_found, i_found, sup_hit, ram_access, snoop_active, word_done;
  logic [AW-1:0]      d_pick, i_pick, sup_pick, rr_idx, arb_next;
  logic [31:0]        req_addr, sup_store;

  always_comb begin
    for (int c = 0; c < CACHE_W; c++) begin
      daddr_w[c]  = daddr[c*32 +: 32];
      iaddr_w[c]  = iaddr[c*32 +: 32];
      dstore_w[c] = dstore[c*32 +: 32];
    end
  end

  // Round-robin search from the arb pointer; data requests are searched before instruction.
  always_comb begin
    dreq    = dREN | dWEN;
    d_found = 1'b0;
    i_found = 1'b0;
    d_pick  = '0;
    i_pick  = '0;
    rr_idx  = '0;
    for (int i = 0; i < CACHE_W; i++) begin
      rr_idx = AW'((int'(arb_q) + i) % CACHE_W);
      if (!d_found && dreq[rr_idx]) begin
        d_found = 1'b1;
        d_pick  = rr_idx;
      end
      if (!i_found && iREN[rr_idx]) begin
        i_found = 1'b1;
        i_pick  = rr_idx;
      end
    end
    sup_hit  = |(cctrans & snoop_dest_q);
    sup_pick = '0;
    for (int c = CACHE_W - 1; c >= 0; c--) begin
      if (cctrans[c] && snoop_dest_q[c]) sup_pick = AW'(c);
    end
  end

  assign ram_access   = (ramstate == RamAccess);
  assign req_addr     = daddr_w[grant_q];
  assign sup_store    = dstore_w[supplier_q];
  assign arb_next     = AW'((int'(grant_q) + 1) % CACHE_W);
  assign snoop_active = !(state_q inside {StIdle, StCacWb, StImem});
  assign word_done    = (state_q inside {StBusWbX1, StBusWbX2}) ? 1'b1 : ram_access;

  always_comb begin
    state_d      = state_q;
    arb_d        = arb_q;
    grant_d      = grant_q;
    supplier_d   = supplier_q;
    snoop_dest_d = snoop_dest_q;
    case (state_q)
      StIdle: begin
        if (d_found) begin
          grant_d      = d_pick;
          snoop_dest_d = ~(CACHE_W'(1) << d_pick);
          if (dWEN[d_pick] && !dREN[d_pick]) state_d = StCacWb;
          else if (ccwrite[d_pick])          state_d = StPrWr;
          else                               state_d = StPrRd;
        end else if (i_found) begin
          grant_d      = i_pick;
          snoop_dest_d = ~(CACHE_W'(1) << i_pick);
          state_d      = StImem;
        end
      end
      StPrRd, StPrWr: begin
        supplier_d = sup_pick;
        if (state_q == StPrRd) state_d = sup_hit ? StBusWb1 : StBusRd1;
        else                   state_d = sup_hit ? StBusWbX1 : StBusRdX1;
      end
      StBusRd1:  if (word_done) state_d = StBusRd2;
      StBusRdX1: if (word_done) state_d = StBusRdX2;
      StBusWb1:  if (word_done) state_d = StBusWb2;
      StBusWbX1: if (word_done) state_d = StBusWbX2;
      StCacWb, StImem, StBusRd2, StBusRdX2, StBusWb2, StBusWbX2: begin
        if (word_done) begin
          state_d = StIdle;
          arb_d   = arb_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      arb_q        <= '0;
      grant_q      <= '0;
      supplier_q   <= '0;
      snoop_dest_q <= '0;
    end else begin
      state_q      <= state_d;
      arb_q        <= arb_d;
      grant_q      <= grant_d;
      supplier_q   <= supplier_d;
      snoop_dest_q <= snoop_dest_d;
    end
  end

  always_comb begin
    dwait    = '1;
    iwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int c = 0; c < CACHE_W; c++) begin
      dload_w[c] = '0;
      iload_w[c] = '0;
    end
    if (snoop_active) ccwait = snoop_dest_q;
    if (state_q inside {StPrWr, StBusRdX1, StBusRdX2, StBusWbX1, StBusWbX2}) ccinv = snoop_dest_q;
    case (state_q)
      StCacWb: begin
        ramWEN   = 1'b1;
        ramaddr  = req_addr;
        ramstore = dstore_w[grant_q];
        if (ram_access) dwait[grant_q] = 1'b0;
      end
      StBusRd1, StBusRd2, StBusRdX1, StBusRdX2: begin
        ramREN  = 1'b1;
        ramaddr = req_addr;
        if (ram_access) begin
          dwait[grant_q]   = 1'b0;
          dload_w[grant_q] = ramload;
        end
      end
      // Supplied data also goes to RAM so the downgraded block is clean in memory.
      StBusWb1, StBusWb2: begin
        ramWEN           = 1'b1;
        ramaddr          = req_addr;
        ramstore         = sup_store;
        dload_w[grant_q] = sup_store;
        if (ram_access) dwait[grant_q] = 1'b0;
      end
      StBusWbX1, StBusWbX2: begin
        dload_w[grant_q] = sup_store;
        dwait[grant_q]   = 1'b0;
      end
      StImem: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_w[grant_q];
        if (ram_access) begin
          iwait[grant_q]   = 1'b0;
          iload_w[grant_q] = ramload;
        end
      end
      default: ;
    endcase
    for (int c = 0; c < CACHE_W; c++) begin
      dload[c*32 +: 32]       = dload_w[c];
      iload[c*32 +: 32]       = iload_w[c];
      ccsnoopaddr[c*32 +: 32] = snoop_active ? req_addr : 32'h0;
    end
  end

`ifdef COHERENCE_STATS_EN
  logic [31:0] c2c_q, c2c_d, rd_q, rd_d;

  always_comb begin
    c2c_d = c2c_q;
    rd_d  = rd_q;
    if (word_done && (state_q inside {StBusWb2, StBusWbX2}) && (c2c_q != 32'hFFFF_FFFF)) begin
      c2c_d = c2c_q + 32'd1;
    end
    if (word_done && (state_q inside {StBusRd2, StBusRdX2, StImem}) && (rd_q != 32'hFFFF_FFFF)) begin
      rd_d = rd_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      c2c_q <= '0;
      rd_q  <= '0;
    end else begin
      c2c_q <= c2c_d;
      rd_q  <= rd_d;
    end
  end

  assign c2c_count    = c2c_q;
  assign ram_rd_count = rd_q;
`else
  // Stats disabled: no counter state.
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (CACHE_W=2) with a bench-driven RAM state.
module tb_coherence_bus_ctrl;

  localparam int unsigned W = 2;
  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Err = 2'd3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [W-1:0]  dREN, dWEN, ccwrite, cctrans, iREN;
  logic [63:0]   daddr, iaddr, dstore;
  logic [W-1:0]  dwait, iwait, ccwait, ccinv;
  logic [63:0]   dload, iload, ccsnoopaddr;
  logic [1:0]    ramstate;
  logic [31:0]   ramload;
  logic          ramREN, ramWEN;
  logic [31:0]   ramaddr, ramstore;
`ifdef COHERENCE_STATS_EN
  logic [31:0]   c2c_count, ram_rd_count;
`endif

  int checks = 0;
  int errors = 0;

  coherence_bus_ctrl #(.CACHE_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .cctrans(cctrans),
    .iREN(iREN), .daddr(daddr), .iaddr(iaddr), .dstore(dstore), .dwait(dwait), .iwait(iwait),
    .dload(dload), .iload(iload), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore)
`ifdef COHERENCE_STATS_EN
    , .c2c_count(c2c_count), .ram_rd_count(ram_rd_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dwait"}, 32'(dwait), 32'h3);
    check({tag, "_iwait"}, 32'(iwait), 32'h3);
    check({tag, "_ccwait"}, 32'(ccwait), 32'h0);
    check({tag, "_ccinv"}, 32'(ccinv), 32'h0);
    check({tag, "_ram_en"}, {30'd0, ramREN, ramWEN}, 32'h0);
    check({tag, "_ramaddr"}, ramaddr, 32'h0);
    check({tag, "_ramstore"}, ramstore, 32'h0);
    check({tag, "_dload"}, dload[31:0] | dload[63:32], 32'h0);
    check({tag, "_iload"}, iload[31:0] | iload[63:32], 32'h0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    settle();
    check_idle("rst");
    check("rst_arb", 32'(dut.arb_q), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
  endtask

  initial begin
    dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; iREN = '0;
    daddr = '0; iaddr = '0; dstore = '0; ramstate = Free; ramload = '0;
    do_reset();

    // 1: BusRd from RAM, two BUSY cycles before ACCESS.
    dREN = 2'b01; daddr[31:0] = 32'h100; ramstate = Busy; ramload = 32'h1111_1111;
    cyc();
    check("t1_prrd_ccwait", 32'(ccwait), 32'h2);
    check("t1_prrd_snoopaddr", ccsnoopaddr[63:32], 32'h100);
    check("t1_prrd_dwait", 32'(dwait), 32'h3);
    check("t1_prrd_ramren", 32'(ramREN), 32'h0);
    cyc();
    check("t1_rd1_ramren", 32'(ramREN), 32'h1);
    check("t1_rd1_ramaddr", ramaddr, 32'h100);
    check("t1_rd1_busy_dwait", 32'(dwait), 32'h3);
    cyc();
    check("t1_rd1_busy2_dwait", 32'(dwait), 32'h3);
    ramstate = Access; settle();
    check("t1_rd1_dwait", 32'(dwait), 32'h2);
    check("t1_rd1_dload", dload[31:0], 32'h1111_1111);
    check("t1_rd1_ccwait", 32'(ccwait), 32'h2);
    cyc();
    daddr[31:0] = 32'h104; ramload = 32'h2222_2222; settle();
    check("t1_rd2_ramaddr", ramaddr, 32'h104);
    check("t1_rd2_dwait", 32'(dwait), 32'h2);
    check("t1_rd2_dload", dload[31:0], 32'h2222_2222);
    check("t1_rd2_ccwait", 32'(ccwait), 32'h2);
    cyc();
    dREN = '0; settle();
    check("t1_end_dwait", 32'(dwait), 32'h3);
    check("t1_end_arb", 32'(dut.arb_q), 32'h1);

    // 2: BusRdX served cache-to-cache, no RAM traffic.
    dREN = 2'b01; ccwrite = 2'b01; daddr[31:0] = 32'h200; cctrans = 2'b10;
    dstore[63:32] = 32'hDEAD_BEEF; ramstate = Free;
    cyc();
    check("t2_prwr_ccwait", 32'(ccwait), 32'h2);
    check("t2_prwr_ccinv", 32'(ccinv), 32'h2);
    check("t2_prwr_ram", {30'd0, ramREN, ramWEN}, 32'h0);
    cyc();
    check("t2_wbx1_dwait", 32'(dwait), 32'h2);
    check("t2_wbx1_dload", dload[31:0], 32'hDEAD_BEEF);
    check("t2_wbx1_ccinv", 32'(ccinv), 32'h2);
    check("t2_wbx1_ram", {30'd0, ramREN, ramWEN}, 32'h0);
    cyc();
    daddr[31:0] = 32'h204; dstore[63:32] = 32'hCAFE_F00D; settle();
    check("t2_wbx2_dwait", 32'(dwait), 32'h2);
    check("t2_wbx2_dload", dload[31:0], 32'hCAFE_F00D);
    check("t2_wbx2_ccinv", 32'(ccinv), 32'h2);
    check("t2_wbx2_ram", {30'd0, ramREN, ramWEN}, 32'h0);
    cyc();
    dREN = '0; ccwrite = '0; cctrans = '0; settle();
    check("t2_end_dwait", 32'(dwait), 32'h3);
    check("t2_end_ccinv", 32'(ccinv), 32'h0);

    // 3: BusRd served by supplier, written through to RAM.
    dREN = 2'b01; daddr[31:0] = 32'h300; cctrans = 2'b10; dstore[63:32] = 32'hA5A5_0001;
    ramstate = Busy;
    cyc();
    check("t3_prrd_ccinv", 32'(ccinv), 32'h0);
    cyc();
    check("t3_wb1_ramwen", {30'd0, ramREN, ramWEN}, 32'h1);
    check("t3_wb1_ramaddr", ramaddr, 32'h300);
    check("t3_wb1_ramstore", ramstore, 32'hA5A5_0001);
    check("t3_wb1_busy_dwait", 32'(dwait), 32'h3);
    ramstate = Access; settle();
    check("t3_wb1_dwait", 32'(dwait), 32'h2);
    check("t3_wb1_dload", dload[31:0], 32'hA5A5_0001);
    cyc();
    daddr[31:0] = 32'h304; dstore[63:32] = 32'hA5A5_0002; settle();
    check("t3_wb2_ramaddr", ramaddr, 32'h304);
    check("t3_wb2_ramstore", ramstore, 32'hA5A5_0002);
    check("t3_wb2_dwait", 32'(dwait), 32'h2);
    cyc();
    dREN = '0; cctrans = '0; settle();
    check("t3_end_ramwen", 32'(ramWEN), 32'h0);

    // 4: data beats instruction, round-robin between data requesters.
    do_reset();
    dREN = 2'b11; iREN = 2'b01; daddr = {32'h600, 32'h500}; iaddr[31:0] = 32'h700;
    ramstate = Access; ramload = 32'h3333_3333;
    cyc();
    check("t4_g0_ccwait", 32'(ccwait), 32'h2);
    cyc();
    check("t4_g0_dwait", 32'(dwait), 32'h2);
    check("t4_g0_ramaddr", ramaddr, 32'h500);
    check("t4_g0_iwait", 32'(iwait), 32'h3);
    cyc();
    cyc();
    dREN = 2'b10; settle();
    check("t4_arb_a", 32'(dut.arb_q), 32'h1);
    cyc();
    check("t4_g1_ccwait", 32'(ccwait), 32'h1);
    cyc();
    check("t4_g1_dwait", 32'(dwait), 32'h1);
    check("t4_g1_ramaddr", ramaddr, 32'h600);
    cyc();
    cyc();
    dREN = '0; settle();
    check("t4_arb_b", 32'(dut.arb_q), 32'h0);
    cyc();
    check("t4_imem_iwait", 32'(iwait), 32'h2);
    check("t4_imem_iload", iload[31:0], 32'h3333_3333);
    check("t4_imem_ramaddr", ramaddr, 32'h700);
    check("t4_imem_dwait", 32'(dwait), 32'h3);
    cyc();
    iREN = '0; settle();
    check("t4_arb_c", 32'(dut.arb_q), 32'h1);
    check("t4_end_iwait", 32'(iwait), 32'h3);

    // 5: write-back held through RAM ERROR, completes once on ACCESS.
    dWEN = 2'b10; daddr[63:32] = 32'h400; dstore[63:32] = 32'h1234_5678; ramstate = Err;
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("t5_err_dwait", 32'(dwait), 32'h3);
      check("t5_err_ramwen", {30'd0, ramREN, ramWEN}, 32'h1);
      check("t5_err_ramaddr", ramaddr, 32'h400);
      if (i < 2) cyc();
    end
    ramstate = Access; settle();
    check("t5_acc_dwait", 32'(dwait), 32'h1);
    check("t5_acc_ramstore", ramstore, 32'h1234_5678);
    cyc();
    dWEN = '0; settle();
    check("t5_end_dwait", 32'(dwait), 32'h3);
    check("t5_end_ramwen", 32'(ramWEN), 32'h0);
    check("t5_end_arb", 32'(dut.arb_q), 32'h0);

    // 6: reset asserted mid-transaction in BUSRD2.
    dREN = 2'b01; daddr[31:0] = 32'h100; cctrans = '0; ramstate = Access;
    cyc();
    cyc();
    cyc();
    ramstate = Busy; settle();
    check("t6_rd2_ramren", 32'(ramREN), 32'h1);
    check("t6_rd2_ccwait", 32'(ccwait), 32'h2);
`ifdef COHERENCE_STATS_EN
    check("t6_pre_rdcnt", ram_rd_count, 32'd3);
    check("t6_pre_c2c", c2c_count, 32'd0);
`endif
    nRST = 1'b0; settle();
    check_idle("t6");
    check("t6_arb", 32'(dut.arb_q), 32'h0);
`ifdef COHERENCE_STATS_EN
    check("t6_rdcnt", ram_rd_count, 32'd0);
    check("t6_c2c", c2c_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
